card_deck: RTL

Card source for the ten-and-a-half game. It answers each draw request (`pip`) from the game controller with one card rank (1..13) taken from a finite 13×COPIES deck, so no rank is dealt more than COPIES times per shuffle. It is the responding end of the controller's `pip`/`number` interface. Randomness comes from a free-running 16-bit LFSR.

---
 rtl/tenthirty_pkg.sv | 33 +++
 rtl/card_deck_lfsr16.sv | 28 ++
 rtl/card_deck.sv | 100 ++++++++++
 3 files changed

// File: rtl/tenthirty_pkg.sv
// ============================================================================
// Module      : tenthirty_pkg
// Description : Shared constants, FSM state type and rank helpers for the
//               ten-and-a-half card source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tenthirty_pkg;

    localparam int RANK_MIN  = 1;
    localparam int RANK_MAX  = 13;
    localparam int NUM_RANKS = 13;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Maps a 4-bit random nibble onto a rank in 1..13.
    function automatic logic [3:0] rank_from_rand(input logic [3:0] r);
        return (r % 4'd13) + 4'd1;
    endfunction

    function automatic logic [3:0] next_rank(input logic [3:0] c);
        return (c == 4'(RANK_MAX)) ? 4'(RANK_MIN) : c + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/card_deck_lfsr16.sv
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Galois LFSR, right-shifting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16
    import tenthirty_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

`default_nettype wire

// File: rtl/card_deck.sv
// ============================================================================
// Module      : card_deck
// Description : Deals ranks 1..13 from a finite 13 x COPIES deck on each
//               rising edge of pip, skipping exhausted ranks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module card_deck
    import tenthirty_pkg::*;
#(
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int          COPIES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pip,
    input  logic       shuffle,
    output logic [3:0] number,
    output logic       valid,
    output logic       empty,
    output logic [5:0] remaining
);

    localparam logic [5:0] FULL     = 6'(NUM_RANKS * COPIES);
    localparam logic [2:0] COPIES_V = 3'(COPIES);

    logic [15:0] lfsr_q;
    logic        unused_lfsr_hi;
    logic        pip_d;
    logic        req;
    state_t      state;
    logic [3:0]  cand;
    logic [3:0]  cand_idx;
    logic [2:0]  cnt [0:NUM_RANKS-1];

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    assign unused_lfsr_hi = ^lfsr_q[15:4];
    assign req            = pip & ~pip_d;
    assign cand_idx       = cand - 4'd1;

    // Shuffle outranks every FSM action, including a deal due this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pip_d     <= 1'b0;
            state     <= IDLE;
            cand      <= 4'(RANK_MIN);
            number    <= 4'd0;
            valid     <= 1'b0;
            empty     <= 1'b0;
            remaining <= FULL;
            for (int r = 0; r < NUM_RANKS; r++) begin
                cnt[r] <= COPIES_V;
            end
        end else begin
            pip_d <= pip;
            valid <= 1'b0;
            if (shuffle) begin
                state     <= IDLE;
                remaining <= FULL;
                empty     <= 1'b0;
                for (int r = 0; r < NUM_RANKS; r++) begin
                    cnt[r] <= COPIES_V;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (req && (remaining != 6'd0)) begin
                            cand  <= rank_from_rand(lfsr_q[3:0]);
                            state <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (cnt[cand_idx] != 3'd0) begin
                            cnt[cand_idx] <= cnt[cand_idx] - 3'd1;
                            remaining     <= remaining - 6'd1;
                            empty         <= (remaining == 6'd1);
                            number        <= cand;
                            valid         <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            cand <= next_rank(cand);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
